relu_maxpool: RTL and testbench



---
 rtl/cnn_pkg.sv | 18 +
 rtl/relu_maxpool_if.sv | 21 ++
 rtl/pool_window_counter.sv | 84 ++++++++
 rtl/relu_maxpool.sv | 146 ++++++++++++++
 tb/tb_relu_maxpool.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/cnn_pkg.sv
// Shared definitions for the CNN pipeline stages: pooling FSM states,
// default element width and an index-width helper.
package cnn_pkg;

    localparam int DEFAULT_WIDTH_BIT = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        WRITE = 2'd2
    } pool_state_t;

    // Bits needed to index 0..n-1, never less than one.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/relu_maxpool_if.sv
// Handshake and data bundle between the convolution stage and relu_maxpool.
// Elements are stored as raw bits; consumers treat each WIDTH_BIT slice as signed.
interface relu_maxpool_if
    import cnn_pkg::*;
#(
    parameter int IN_SIZE   = 5,
    parameter int POOL      = 2,
    parameter int WIDTH_BIT = DEFAULT_WIDTH_BIT
);
    localparam int OUT_SIZE = IN_SIZE / POOL;

    logic                                               start;
    logic [IN_SIZE-1:0][IN_SIZE-1:0][WIDTH_BIT-1:0]     featMapIn;
    logic                                               busy;
    logic                                               done;
    logic [OUT_SIZE-1:0][OUT_SIZE-1:0][WIDTH_BIT-1:0]   poolOut;

    modport master (output start, featMapIn, input busy, done, poolOut);
    modport slave  (input start, featMapIn, output busy, done, poolOut);

endinterface

// File: rtl/pool_window_counter.sv
// Nested window/element counter: kj fastest, wrapping into ki; oj wrapping into oi.
// advance_win also rewinds the element indices for the next window.
module pool_window_counter
    import cnn_pkg::*;
#(
    parameter int POOL     = 2,
    parameter int OUT_SIZE = 2,
    parameter int IW       = 3
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          clear_i,
    input  logic          advance_elem_i,
    input  logic          advance_win_i,
    output logic [IW-1:0] oi_o,
    output logic [IW-1:0] oj_o,
    output logic [IW-1:0] ki_o,
    output logic [IW-1:0] kj_o,
    output logic          last_elem_o,
    output logic          last_win_o
);
    localparam logic [IW-1:0] K_MAX = IW'(POOL - 1);
    localparam logic [IW-1:0] W_MAX = IW'(OUT_SIZE - 1);
    localparam logic [IW-1:0] ONE   = IW'(1);
    localparam logic [IW-1:0] ZERO  = {IW{1'b0}};

    logic [IW-1:0] oi_q, oj_q, ki_q, kj_q;
    logic [IW-1:0] oi_d, oj_d, ki_d, kj_d;

    assign last_elem_o = (ki_q == K_MAX) && (kj_q == K_MAX);
    assign last_win_o  = (oi_q == W_MAX) && (oj_q == W_MAX);
    assign oi_o = oi_q;
    assign oj_o = oj_q;
    assign ki_o = ki_q;
    assign kj_o = kj_q;

    // Next-index computation; window advance takes priority over element advance.
    always_comb begin
        oi_d = oi_q;
        oj_d = oj_q;
        ki_d = ki_q;
        kj_d = kj_q;
        if (clear_i) begin
            oi_d = ZERO;
            oj_d = ZERO;
            ki_d = ZERO;
            kj_d = ZERO;
        end else if (advance_win_i) begin
            ki_d = ZERO;
            kj_d = ZERO;
            if (oj_q == W_MAX) begin
                oj_d = ZERO;
                oi_d = (oi_q == W_MAX) ? ZERO : oi_q + ONE;
            end else begin
                oj_d = oj_q + ONE;
            end
        end else if (advance_elem_i) begin
            if (kj_q == K_MAX) begin
                kj_d = ZERO;
                ki_d = (ki_q == K_MAX) ? ZERO : ki_q + ONE;
            end else begin
                kj_d = kj_q + ONE;
            end
        end else begin
            oi_d = oi_q;
        end
    end

    // Index registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            oi_q <= ZERO;
            oj_q <= ZERO;
            ki_q <= ZERO;
            kj_q <= ZERO;
        end else begin
            oi_q <= oi_d;
            oj_q <= oj_d;
            ki_q <= ki_d;
            kj_q <= kj_d;
        end
    end

endmodule

// File: rtl/relu_maxpool.sv
// Sequential ReLU + non-overlapping max-pool. Snapshots the feature map on
// start, scans each POOLxPOOL window one element per cycle, and writes
// max(0, window max) into the pooled map. Accumulator starting at zero
// provides the ReLU for free.
module relu_maxpool
    import cnn_pkg::*;
#(
    parameter int IN_SIZE   = 5,
    parameter int POOL      = 2,
    parameter int WIDTH_BIT = DEFAULT_WIDTH_BIT
) (
    input  logic           clock,
    input  logic           reset,
    relu_maxpool_if.slave  bus
);
    localparam int OUT_SIZE = IN_SIZE / POOL;
    localparam int IW       = idx_width(IN_SIZE);

    pool_state_t state_q, state_d;

    logic [IN_SIZE-1:0][IN_SIZE-1:0][WIDTH_BIT-1:0]   fm_q;
    logic [OUT_SIZE-1:0][OUT_SIZE-1:0][WIDTH_BIT-1:0] pool_q;
    logic signed [WIDTH_BIT-1:0] acc_q, acc_d;
    logic busy_q, busy_d;
    logic done_q, done_d;

    logic capture_s, adv_elem_s, adv_win_s, write_s;
    logic [IW-1:0] oi_s, oj_s, ki_s, kj_s;
    logic last_elem_s, last_win_s;
    logic [IW-1:0] row_s, col_s;
    logic signed [WIDTH_BIT-1:0] elem_s;

    pool_window_counter #(
        .POOL     (POOL),
        .OUT_SIZE (OUT_SIZE),
        .IW       (IW)
    ) u_cnt (
        .clock          (clock),
        .reset          (reset),
        .clear_i        (capture_s),
        .advance_elem_i (adv_elem_s),
        .advance_win_i  (adv_win_s),
        .oi_o           (oi_s),
        .oj_o           (oj_s),
        .ki_o           (ki_s),
        .kj_o           (kj_s),
        .last_elem_o    (last_elem_s),
        .last_win_o     (last_win_s)
    );

    // Trailing rows/columns beyond OUT_SIZE*POOL are never addressed.
    assign row_s  = IW'(32'(oi_s) * POOL + 32'(ki_s));
    assign col_s  = IW'(32'(oj_s) * POOL + 32'(kj_s));
    assign elem_s = fm_q[row_s][col_s];

    // FSM next-state, accumulator update and datapath strobes.
    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        capture_s  = 1'b0;
        adv_elem_s = 1'b0;
        adv_win_s  = 1'b0;
        write_s    = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    capture_s = 1'b1;
                    acc_d     = {WIDTH_BIT{1'b0}};
                    busy_d    = 1'b1;
                    state_d   = SCAN;
                end else begin
                    state_d   = IDLE;
                end
            end
            SCAN: begin
                adv_elem_s = 1'b1;
                if (elem_s > acc_q) begin
                    acc_d = elem_s;
                end else begin
                    acc_d = acc_q;
                end
                if (last_elem_s) begin
                    state_d = WRITE;
                end else begin
                    state_d = SCAN;
                end
            end
            WRITE: begin
                write_s   = 1'b1;
                adv_win_s = 1'b1;
                acc_d     = {WIDTH_BIT{1'b0}};
                if (last_win_s) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else begin
                    state_d = SCAN;
                end
            end
            default: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // Control and accumulator registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            acc_q   <= {WIDTH_BIT{1'b0}};
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Feature-map snapshot, taken only on the accepted start edge.
    always_ff @(posedge clock) begin
        if (reset) begin
            fm_q <= '0;
        end else if (capture_s) begin
            fm_q <= bus.featMapIn;
        end
    end

    // Pooled output map; entries persist until overwritten by the next run.
    always_ff @(posedge clock) begin
        if (reset) begin
            pool_q <= '0;
        end else if (write_s) begin
            pool_q[oi_s][oj_s] <= acc_q;
        end
    end

    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.poolOut = pool_q;

endmodule

// File: tb/tb_relu_maxpool.sv
// Directed, table-driven bench for relu_maxpool with default parameters.
module tb_relu_maxpool;

    typedef logic [4:0][4:0][7:0] fm_t;
    typedef logic [1:0][1:0][7:0] pool_t;
    typedef struct {
        string name;
        fm_t   fm;
        pool_t exp;
    } vec_t;

    logic clock;
    logic reset;
    int   checks;
    int   failures;

    relu_maxpool_if #(.IN_SIZE(5), .POOL(2), .WIDTH_BIT(8)) bus ();

    relu_maxpool #(.IN_SIZE(5), .POOL(2), .WIDTH_BIT(8)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic fm_t fm_ramp();
        fm_t f;
        for (int r = 0; r < 5; r++)
            for (int c = 0; c < 5; c++)
                f[r][c] = 8'(5 * r + c);
        return f;
    endfunction

    function automatic fm_t fm_const(input logic [7:0] v);
        fm_t f;
        for (int r = 0; r < 5; r++)
            for (int c = 0; c < 5; c++)
                f[r][c] = v;
        return f;
    endfunction

    function automatic pool_t mk_pool(input logic [7:0] a, input logic [7:0] b,
                                      input logic [7:0] c, input logic [7:0] d);
        pool_t p;
        p[0][0] = a;
        p[0][1] = b;
        p[1][0] = c;
        p[1][1] = d;
        return p;
    endfunction

    // Drive a start for one edge (edge 0) and check busy right after it.
    task automatic start_run(input fm_t fm, input string name);
        @(negedge clock);
        bus.featMapIn = fm;
        bus.start     = 1'b1;
        @(posedge clock);
        #1;
        bus.start = 1'b0;
        check({name, " busy_after_start"}, 64'(bus.busy), 64'd1);
    endtask

    // Count edges after edge 0 until done is seen; -1 if it never comes.
    task automatic wait_done(output int k);
        k = -1;
        for (int i = 1; i <= 60; i++) begin
            @(posedge clock);
            #1;
            if (bus.done) begin
                k = i;
                break;
            end
        end
    endtask

    vec_t vecs[5];
    fm_t  f;
    int   k;
    int   done_edges[$];
    int   seen;

    initial begin
        checks    = 0;
        failures  = 0;
        reset     = 1'b1;
        bus.start = 1'b0;
        bus.featMapIn = '0;

        f = fm_ramp();
        vecs[0] = '{"ramp", f, mk_pool(8'd6, 8'd8, 8'd16, 8'd18)};
        vecs[1] = '{"all_neg3", fm_const(8'hFD), mk_pool(8'd0, 8'd0, 8'd0, 8'd0)};
        f = fm_const(8'd0);
        f[2][3] = 8'h80;
        f[3][2] = 8'h7F;
        vecs[2] = '{"extremes", f, mk_pool(8'd0, 8'd0, 8'd0, 8'h7F)};
        f = fm_const(8'd0);
        for (int i = 0; i < 5; i++) begin
            f[4][i] = 8'd100;
            f[i][4] = 8'd100;
        end
        vecs[3] = '{"trailing", f, mk_pool(8'd0, 8'd0, 8'd0, 8'd0)};
        f = fm_const(8'hF0);
        f[0][0] = 8'hFF;
        f[1][1] = 8'd3;
        f[0][2] = 8'h7F;
        f[1][3] = 8'h80;
        f[2][0] = 8'h80;
        f[2][2] = 8'd0;
        f[3][3] = 8'd1;
        vecs[4] = '{"mixed", f, mk_pool(8'd3, 8'h7F, 8'd0, 8'd1)};

        repeat (2) @(posedge clock);
        #1;
        check("reset_busy", 64'(bus.busy), 64'd0);
        check("reset_done", 64'(bus.done), 64'd0);
        check("reset_pool", 64'(bus.poolOut), 64'd0);
        reset = 1'b0;

        // Table-driven runs.
        for (int v = 0; v < 5; v++) begin
            start_run(vecs[v].fm, vecs[v].name);
            wait_done(k);
            check({vecs[v].name, " done_edge"}, 64'(k), 64'd20);
            check({vecs[v].name, " pool"}, 64'(bus.poolOut), 64'(vecs[v].exp));
            check({vecs[v].name, " busy_at_done"}, 64'(bus.busy), 64'd0);
            @(posedge clock);
            #1;
            check({vecs[v].name, " done_pulse"}, 64'(bus.done), 64'd0);
            repeat (3) @(posedge clock);
            #1;
            check({vecs[v].name, " pool_hold"}, 64'(bus.poolOut), 64'(vecs[v].exp));
        end

        // start held for 25 edges: runs accepted at edges 0 and 21.
        @(negedge clock);
        bus.featMapIn = fm_ramp();
        bus.start     = 1'b1;
        @(posedge clock);
        #1;
        for (int e = 1; e <= 60; e++) begin
            @(posedge clock);
            #1;
            if (e == 24) bus.start = 1'b0;
            if (bus.done) done_edges.push_back(e);
        end
        check("held_done_count", 64'(done_edges.size()), 64'd2);
        if (done_edges.size() == 2) begin
            check("held_done_edge0", 64'(done_edges[0]), 64'd20);
            check("held_done_edge1", 64'(done_edges[1]), 64'd41);
        end
        check("held_pool", 64'(bus.poolOut), 64'(mk_pool(8'd6, 8'd8, 8'd16, 8'd18)));

        // Input changed after capture must not affect the run.
        start_run(vecs[4].fm, "late_change");
        bus.featMapIn = fm_const(8'd100);
        wait_done(k);
        check("late_change done_edge", 64'(k), 64'd20);
        check("late_change pool", 64'(bus.poolOut), 64'(vecs[4].exp));
        @(posedge clock);
        #1;

        // Reset at edge 7 aborts the run and clears outputs.
        start_run(fm_ramp(), "abort");
        repeat (6) @(posedge clock);
        #1;
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        check("abort_busy", 64'(bus.busy), 64'd0);
        check("abort_done", 64'(bus.done), 64'd0);
        check("abort_pool", 64'(bus.poolOut), 64'd0);
        start_run(vecs[2].fm, "after_abort");
        wait_done(k);
        check("after_abort done_edge", 64'(k), 64'd20);
        check("after_abort pool", 64'(bus.poolOut), 64'(vecs[2].exp));
        @(posedge clock);
        #1;

        // Reset and start on the same edge: no run.
        @(negedge clock);
        bus.featMapIn = fm_ramp();
        reset     = 1'b1;
        bus.start = 1'b1;
        @(posedge clock);
        #1;
        reset     = 1'b0;
        bus.start = 1'b0;
        seen = 0;
        for (int e = 0; e < 25; e++) begin
            if (bus.busy || bus.done) seen++;
            @(posedge clock);
            #1;
        end
        check("rst_start_no_run", 64'(seen), 64'd0);
        check("rst_start_pool", 64'(bus.poolOut), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
